// File: rtl/bf_uart_input_pkg.sv
// Shared constants and handshake state encodings for the UART receive bridge.
package bf_uart_input_pkg;

  localparam int BF_DATA_WIDTH         = 8;
  localparam int INPUT_FIFO_DEPTH_LOG2 = 4;

  typedef enum logic {
    IN_IDLE = 1'b0,
    IN_ACK  = 1'b1
  } in_state_t;

endpackage

// File: rtl/bf_uart_input_sync_fifo.sv
// Synchronous circular-buffer FIFO with occupancy count; a write is accepted
// when full only if a read happens in the same cycle.
module bf_uart_input_sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  // count never exceeds DEPTH, so its top bit alone marks full
  assign full    = count[DEPTH_LOG2];
  assign empty   = (count == '0);
  assign do_pop  = rd_en && !empty;
  assign do_push = wr_en && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (do_pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (DEPTH_LOG2 + 1)'(1);
        2'b01:   count <= count - (DEPTH_LOG2 + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // A full push+pop writes the slot being read; rd_data is sampled before the edge.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/bf_uart_input.sv
// Receive bridge: buffers UART bytes and hands one to the core per request
// through a req/valid handshake, with a sticky overflow flag for dropped bytes.
//
// state   | meaning
// IN_IDLE | waiting for input_req with a non-empty FIFO; pop and latch data
// IN_ACK  | input_valid high for this cycle only; input_req ignored
module bf_uart_input
  import bf_uart_input_pkg::*;
#(
  parameter int DATA_WIDTH = BF_DATA_WIDTH,
  parameter int DEPTH_LOG2 = INPUT_FIFO_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_done,
  input  logic                  input_req,
  output logic                  input_valid,
  output logic [DATA_WIDTH-1:0] input_data,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  overflow,
  input  logic                  overflow_clr
);

  in_state_t             state_q;
  in_state_t             state_d;
  logic                  pop;
  logic                  drop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rd_data;

  assign pop  = (state_q == IN_IDLE) && input_req && !fifo_empty;
  assign drop = rx_done && fifo_full && !pop;

  bf_uart_input_sync_fifo #(
    .WIDTH      (DATA_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (rx_done),
    .wr_data (rx_data),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    input_valid = 1'b0;
    case (state_q)
      IN_IDLE: if (pop) state_d = IN_ACK;
      IN_ACK: begin
        input_valid = 1'b1;
        state_d     = IN_IDLE;
      end
      default: state_d = IN_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IN_IDLE;
      input_data <= '0;
      overflow   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (pop) input_data <= fifo_rd_data;
      // a drop in the same cycle outranks a clear
      if (drop)              overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bf_uart_input.sv
// Self-checking bench for bf_uart_input: vector table, directed corner cases,
// and a randomized run compared against a queue-based reference model.
module tb_bf_uart_input;

  localparam int DW    = 8;
  localparam int DL    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] rx_data;
  logic          rx_done;
  logic          input_req;
  logic          input_valid;
  logic [DW-1:0] input_data;
  logic [DL:0]   fifo_count;
  logic          overflow;
  logic          overflow_clr;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  byte unsigned m_q[$];
  bit           m_ack;
  bit           m_ovf;
  logic [7:0]   m_data;

  bf_uart_input #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_done      (rx_done),
    .input_req    (input_req),
    .input_valid  (input_valid),
    .input_data   (input_data),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit r, input bit rd, input logic [7:0] d, input bit q, input bit c);
    rst          = r;
    rx_done      = rd;
    rx_data      = d;
    input_req    = q;
    overflow_clr = c;
  endtask

  // Advance the model by one edge using the inputs currently applied.
  task automatic model_edge();
    bit pop;
    bit push;
    if (rst) begin
      m_q.delete();
      m_ack  = 0;
      m_ovf  = 0;
      m_data = 8'h00;
    end else begin
      pop  = !m_ack && input_req && (m_q.size() > 0);
      push = rx_done && ((m_q.size() < DEPTH) || pop);
      if (pop) m_data = m_q.pop_front();
      if (push) m_q.push_back(rx_data);
      if (rx_done && !push) m_ovf = 1;
      else if (overflow_clr) m_ovf = 0;
      m_ack = pop;
    end
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check({tag, "_valid"}, input_valid, m_ack);
    check({tag, "_data"},  input_data,  m_data);
    check({tag, "_count"}, fifo_count,  m_q.size());
    check({tag, "_ovf"},   overflow,    m_ovf);
  endtask

  typedef struct {
    bit         rst;
    bit         rxd;
    logic [7:0] d;
    bit         req;
    bit         clr;
    bit         ev;
    logic [7:0] ed;
    int         ec;
    bit         eo;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic [7:0] exp_b;

    // rst rxd data  req clr | valid data count ovf
    vecs[0]  = '{1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0};
    vecs[1]  = '{0, 1, 8'h2B, 0, 0, 0, 8'h00, 1, 0};
    vecs[2]  = '{0, 0, 8'h00, 1, 0, 1, 8'h2B, 0, 0};
    vecs[3]  = '{0, 0, 8'h00, 1, 0, 0, 8'h2B, 0, 0};
    vecs[4]  = '{0, 0, 8'h00, 1, 0, 0, 8'h2B, 0, 0};
    vecs[5]  = '{0, 1, 8'h11, 0, 0, 0, 8'h2B, 1, 0};
    vecs[6]  = '{0, 1, 8'h22, 0, 0, 0, 8'h2B, 2, 0};
    vecs[7]  = '{0, 1, 8'h33, 0, 0, 0, 8'h2B, 3, 0};
    vecs[8]  = '{0, 0, 8'h00, 1, 0, 1, 8'h11, 2, 0};
    vecs[9]  = '{1, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0};
    vecs[10] = '{0, 1, 8'h44, 1, 0, 0, 8'h00, 1, 0};
    vecs[11] = '{0, 0, 8'h00, 1, 0, 1, 8'h44, 0, 0};
    vecs[12] = '{0, 0, 8'h00, 0, 0, 0, 8'h44, 0, 0};

    drive(1, 0, 8'h00, 0, 0);
    m_data = 8'h00;

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].rst, vecs[i].rxd, vecs[i].d, vecs[i].req, vecs[i].clr);
      step("vec");
      check($sformatf("vec%0d_valid", i), input_valid, vecs[i].ev);
      check($sformatf("vec%0d_data", i),  input_data,  vecs[i].ed);
      check($sformatf("vec%0d_count", i), fifo_count,  vecs[i].ec);
      check($sformatf("vec%0d_ovf", i),   overflow,    vecs[i].eo);
    end

    // Request held on an empty FIFO: nothing is delivered until a byte arrives.
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 8'h00, 1, 0);
      step("wait");
      check("wait_valid_low", input_valid, 1'b0);
    end
    drive(0, 1, 8'h41, 1, 0);
    step("wait_push");
    check("wait_push_valid", input_valid, 1'b0);
    drive(0, 0, 8'h00, 1, 0);
    step("wait_pop");
    check("wait_pop_valid", input_valid, 1'b1);
    check("wait_pop_data", input_data, 8'h41);
    drive(0, 0, 8'h00, 0, 0);
    step("wait_idle");

    // Fill to full, then overflow behaviour.
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 1, 8'(i), 0, 0);
      step("fill");
    end
    check("full_count", fifo_count, 16);
    check("full_ovf", overflow, 1'b0);
    drive(0, 1, 8'h10, 0, 0);
    step("drop");
    check("drop_count", fifo_count, 16);
    check("drop_ovf", overflow, 1'b1);
    drive(0, 1, 8'h66, 0, 1);
    step("drop_clr");
    check("drop_clr_ovf", overflow, 1'b1);
    drive(0, 0, 8'h00, 0, 1);
    step("clr");
    check("clr_ovf", overflow, 1'b0);

    // Full with simultaneous pop: push accepted, count unchanged.
    drive(0, 1, 8'h55, 1, 0);
    step("full_pp");
    check("full_pp_valid", input_valid, 1'b1);
    check("full_pp_data", input_data, 8'h00);
    check("full_pp_count", fifo_count, 16);
    check("full_pp_ovf", overflow, 1'b0);
    drive(0, 0, 8'h00, 1, 0);
    step("full_pp_ack");
    check("full_pp_ack_valid", input_valid, 1'b0);

    // Drain across the pointer wrap.
    for (int i = 1; i <= DEPTH; i++) begin
      exp_b = (i < DEPTH) ? 8'(i) : 8'h55;
      drive(0, 0, 8'h00, 1, 0);
      step("drain");
      check($sformatf("drain%0d_valid", i), input_valid, 1'b1);
      check($sformatf("drain%0d_data", i), input_data, exp_b);
      step("drain_ack");
      check($sformatf("drain%0d_ack", i), input_valid, 1'b0);
    end
    check("drained_count", fifo_count, 0);
    drive(0, 0, 8'h00, 0, 0);
    step("idle");

    // Randomized traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(199) == 0, $urandom_range(1) == 1, 8'($urandom),
            ((c % 400) < 200) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0),
            $urandom_range(9) == 0);
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
